// File: rtl/mem_access_unit_pkg.sv
// Shared RV32I access-size encodings and MEM-stage access FSM state type.
package rv32i_types;

  localparam int BYTE_LANES = 4;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_store_format.sv
// Store lane formatting: byte enables and replicated write data from size and address offset.
// Also flags misaligned halfword/word accesses (low funct3 bits encode size for loads and stores).
module store_format
  import rv32i_types::*;
(
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [31:0]           rs2_i,
  output logic [31:0]           wdata_o,
  output logic [BYTE_LANES-1:0] byte_enable_o,
  output logic                  misaligned_o
);

  always_comb begin
    wdata_o       = rs2_i;
    byte_enable_o = 4'b0000;
    case (funct3_i)
      sb: begin
        byte_enable_o = 4'b0001 << addr_lo_i;
        wdata_o       = {4{rs2_i[7:0]}};
      end
      sh: begin
        byte_enable_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o       = {2{rs2_i[15:0]}};
      end
      sw: begin
        byte_enable_o = 4'b1111;
      end
      default: ;
    endcase
  end

  assign misaligned_o = ((funct3_i[1:0] == 2'b01) & addr_lo_i[0]) |
                        ((funct3_i[1:0] == 2'b10) & (|addr_lo_i));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: holds one dcache request per load/store and stalls until dmem_resp.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses skip the cache and raise misaligned_trap.
module mem_access_unit
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_mem_read,
  input  logic                  MEM_mem_write,
  input  logic [2:0]            MEM_funct3,
  input  logic [31:0]           MEM_alu_out,
  input  logic [31:0]           MEM_rs2_out,
  input  logic                  dmem_resp,
  input  logic [31:0]           dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [31:0]           dmem_address,
  output logic [31:0]           dmem_wdata,
  output logic [BYTE_LANES-1:0] dmem_byte_enable,
  output logic [31:0]           MEM_rdata,
  output logic                  mem_stall,
  output logic                  misaligned_trap
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;

  logic [1:0]            state_q, state_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  trap_d;

  logic                  req;
  logic                  take_trap;
  logic [31:0]           fmt_wdata;
  logic [BYTE_LANES-1:0] fmt_be;
  logic                  fmt_misaligned;

  store_format u_store_format (
    .funct3_i      (MEM_funct3),
    .addr_lo_i     (MEM_alu_out[1:0]),
    .rs2_i         (MEM_rs2_out),
    .wdata_o       (fmt_wdata),
    .byte_enable_o (fmt_be),
    .misaligned_o  (fmt_misaligned)
  );

  assign req = MEM_mem_read | MEM_mem_write;

`ifdef MISALIGN_TRAP_EN
  logic trap_q;
  assign take_trap       = fmt_misaligned;
  assign misaligned_trap = trap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = fmt_misaligned ^ trap_d;
  assign take_trap         = 1'b0;
  assign misaligned_trap   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    trap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (take_trap) begin
            state_d = S_DONE;
            trap_d  = 1'b1;
          end else begin
            // Write wins when both request flags are set.
            state_d = S_ACCESS;
            wr_d    = MEM_mem_write;
            rd_d    = ~MEM_mem_write;
            addr_d  = {MEM_alu_out[31:2], 2'b00};
            wdata_d = MEM_mem_write ? fmt_wdata : 32'h0;
            be_d    = MEM_mem_write ? fmt_be : 4'b1111;
            off_d   = MEM_alu_out[1:0];
          end
        end
      end
      S_ACCESS: begin
        if (dmem_resp) begin
          if (rd_q) rdata_d = dmem_rdata >> {off_q, 3'b000};
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign MEM_rdata        = rdata_q;
  assign mem_stall        = ((state_q == S_IDLE) & req) | (state_q == S_ACCESS);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_mem_read, MEM_mem_write;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_alu_out, MEM_rs2_out;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] MEM_rdata;
  logic        mem_stall, misaligned_trap;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .MEM_mem_read     (MEM_mem_read),
    .MEM_mem_write    (MEM_mem_write),
    .MEM_funct3       (MEM_funct3),
    .MEM_alu_out      (MEM_alu_out),
    .MEM_rs2_out      (MEM_rs2_out),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .MEM_rdata        (MEM_rdata),
    .mem_stall        (mem_stall),
    .misaligned_trap  (misaligned_trap)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_wd;
  } req_t;

  typedef struct {
    int          cycles;
    logic [31:0] rdata;
    logic        trap;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic mon_en     = 1'b1;
  logic prev_req   = 1'b0;
  logic prev_stall = 1'b0;
  int   stall_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic chk_wd);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.be = be; r.chk_wd = chk_wd;
    req_q.push_back(r);
  endtask

  task automatic push_done(input int cycles, input logic [31:0] rdata, input logic trap);
    done_t d;
    d.cycles = cycles; d.rdata = rdata; d.trap = trap;
    done_q.push_back(d);
  endtask

  // Monitor: request fields on the first cycle a request appears; latency/data/trap when stall drops.
  always @(negedge clk) begin
    logic  req_now;
    req_t  r;
    done_t d;
    req_now = dmem_read | dmem_write;
    if (rst || !mon_en) begin
      stall_cnt = 0;
    end else begin
      if (req_now && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", {30'h0, dmem_read, dmem_write}, 32'h0);
        end else begin
          r = req_q.pop_front();
          chk("req_rd", {31'h0, dmem_read}, {31'h0, r.rd});
          chk("req_wr", {31'h0, dmem_write}, {31'h0, r.wr});
          chk("req_addr", dmem_address, r.addr);
          chk("req_be", {28'h0, dmem_byte_enable}, {28'h0, r.be});
          if (r.chk_wd) chk("req_wdata", dmem_wdata, r.wdata);
        end
      end
      if (mem_stall) begin
        stall_cnt++;
      end else if (prev_stall) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(stall_cnt), 32'h0);
        end else begin
          d = done_q.pop_front();
          chk("stall_cycles", 32'(stall_cnt), 32'(d.cycles));
          chk("done_rdata", MEM_rdata, d.rdata);
          chk("done_trap", {31'h0, misaligned_trap}, {31'h0, d.trap});
          chk("done_no_req", {31'h0, req_now}, 32'h0);
        end
        stall_cnt = 0;
      end
    end
    prev_req   = req_now;
    prev_stall = mem_stall;
  end

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input int k, input logic [31:0] rdata);
    MEM_mem_read  = rd;
    MEM_mem_write = wr;
    MEM_funct3    = f3;
    MEM_alu_out   = addr;
    MEM_rs2_out   = rs2;
    for (int i = 1; i <= k; i++) begin
      @(posedge clk); #1;
      if (i == k) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
      end
    end
    @(posedge clk); #1;
    dmem_resp     = 1'b0;
    dmem_rdata    = 32'h0;
    MEM_mem_read  = 1'b0;
    MEM_mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    MEM_mem_read = 1'b0; MEM_mem_write = 1'b0; MEM_funct3 = 3'b0;
    MEM_alu_out = 32'h0; MEM_rs2_out = 32'h0;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", {31'h0, dmem_read}, 32'h0);
    chk("rst_write", {31'h0, dmem_write}, 32'h0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_be", {28'h0, dmem_byte_enable}, 32'h0);
    chk("rst_rdata", MEM_rdata, 32'h0);
    chk("rst_trap", {31'h0, misaligned_trap}, 32'h0);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW, resp two cycles after request detect
    push_req(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b1);
    push_done(3, 32'h0, 1'b0);
    access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);

    // SB at byte 3
    push_req(1'b0, 1'b1, 32'h200, 32'hABABABAB, 4'b1000, 1'b1);
    push_done(2, 32'h0, 1'b0);
    access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000AB, 1, 32'h0);

    // LH at offset 2
    push_req(1'b1, 1'b0, 32'h300, 32'h0, 4'b1111, 1'b0);
    push_done(2, 32'h00008001, 1'b0);
    access(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 1, 32'h80011234);

    // Back-to-back LW then SH, zero-wait responses
    push_req(1'b1, 1'b0, 32'h400, 32'h0, 4'b1111, 1'b0);
    push_done(2, 32'h11223344, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1, 32'h11223344);
    push_req(1'b0, 1'b1, 32'h400, 32'hCAFECAFE, 4'b1100, 1'b1);
    push_done(2, 32'h11223344, 1'b0);
    access(1'b0, 1'b1, 3'b001, 32'h402, 32'h0000CAFE, 1, 32'h0);

    // SB at byte 1, both read and write set: write wins
    push_req(1'b0, 1'b1, 32'h000, 32'h12121212, 4'b0010, 1'b1);
    push_done(2, 32'h11223344, 1'b0);
    access(1'b1, 1'b1, 3'b000, 32'h001, 32'h00003412, 1, 32'h0);

    // Undefined store funct3: no-op mask, still completes
    push_req(1'b0, 1'b1, 32'h500, 32'h0, 4'b0000, 1'b0);
    push_done(2, 32'h11223344, 1'b0);
    access(1'b0, 1'b1, 3'b011, 32'h500, 32'h55555555, 1, 32'h0);

    // LBU at byte 3, long wait
    push_req(1'b1, 1'b0, 32'h500, 32'h0, 4'b1111, 1'b0);
    push_done(4, 32'h000000A1, 1'b0);
    access(1'b1, 1'b0, 3'b100, 32'h503, 32'h0, 3, 32'hA1B2C3D4);

    // Reset mid-ACCESS aborts the load; the late resp is ignored
    mon_en = 1'b0;
    MEM_mem_read = 1'b1; MEM_funct3 = 3'b010; MEM_alu_out = 32'h600;
    @(posedge clk); #1;
    chk("abort_pre_read", {31'h0, dmem_read}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_read", {31'h0, dmem_read}, 32'h0);
    chk("abort_addr", dmem_address, 32'h0);
    chk("abort_rdata", MEM_rdata, 32'h0);
    MEM_mem_read = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    chk("late_resp_read", {31'h0, dmem_read}, 32'h0);
    chk("late_resp_stall", {31'h0, mem_stall}, 32'h0);
    chk("late_resp_rdata", MEM_rdata, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Misaligned LW at 0x101
`ifdef MISALIGN_TRAP_EN
    push_done(1, 32'h0, 1'b1);
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
`else
    push_req(1'b1, 1'b0, 32'h100, 32'h0, 4'b1111, 1'b0);
    push_done(2, 32'h00CAFEF0, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'hCAFEF00D);
`endif
    chk("trap_one_cycle", {31'h0, misaligned_trap}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", 32'(req_q.size()), 32'h0);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
